// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment display path: decoder code width
// and the special non-hex codes understood by the downstream decoder.
package seg7_pkg;

    localparam int SEG_CODE_W = 5;

    typedef logic [SEG_CODE_W-1:0] seg_code_t;

    localparam seg_code_t CODE_DASH  = 5'h10;
    localparam seg_code_t CODE_BLANK = 5'h1F;

endpackage

// File: rtl/seg7_prescaler.sv
// Free-running modulo-DIV counter with a terminal-count strobe; shared by the
// display scanner and other board timers.
module seg7_prescaler #(
    parameter int DIV   = 100000,
    parameter int CNT_W = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    assign tc = en && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scanner for the multi-digit seven-segment display: holds a
// frame-synchronous display value and drives decoder codes plus anode enables.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int GUARD_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           value,
    input  logic                  load,
    input  logic                  lz_en,
    input  logic                  dash_mode,
    input  logic [NUM_DIGITS-1:0] en_mask,
    output logic [4:0]            digit_code,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  frame_start
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] GUARD_END = CNT_W'(GUARD_CYCLES);

    logic [CNT_W-1:0]      presc;
    logic                  tc;
    logic                  fb;
    logic [IDX_W-1:0]      idx;
    logic [31:0]           active_val;
    logic [31:0]           pending_val;
    logic                  pending;

    seg_code_t             code_p0;
    logic [NUM_DIGITS-1:0] an_p0;
    seg_code_t             code_p1;
    logic [NUM_DIGITS-1:0] an_p1;
    logic                  fs_p1;

    // Leading-zero blanking applies only above digit 0, so a zero value still
    // shows a single "0".
    function automatic seg_code_t select_code(
        input logic [31:0]           val,
        input int                    sel,
        input logic [NUM_DIGITS-1:0] mask,
        input logic                  lz,
        input logic                  dash
    );
        logic upper_zero;
        upper_zero = 1'b1;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (d >= sel && val[d*4 +: 4] != 4'h0) begin
                upper_zero = 1'b0;
            end
        end
        if (!mask[sel]) begin
            return CODE_BLANK;
        end else if (dash) begin
            return CODE_DASH;
        end else if (lz && sel > 0 && upper_zero) begin
            return CODE_BLANK;
        end else begin
            return {1'b0, val[sel*4 +: 4]};
        end
    endfunction

    function automatic logic [NUM_DIGITS-1:0] anode_pattern(
        input int                    sel,
        input logic                  lit,
        input logic [NUM_DIGITS-1:0] mask
    );
        logic [NUM_DIGITS-1:0] pat;
        pat = '1;
        if (lit && mask[sel]) begin
            pat[sel] = 1'b0;
        end
        return pat;
    endfunction

    seg7_prescaler #(
        .DIV   (REFRESH_DIV),
        .CNT_W (CNT_W)
    ) u_presc (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .cnt   (presc),
        .tc    (tc)
    );

    assign fb = tc && (idx == IDX_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (tc) begin
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end
    end

    // A load landing on the frame boundary bypasses the pending register so
    // it is shown from the very next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_val  <= '0;
            pending_val <= '0;
            pending     <= 1'b0;
        end else begin
            if (load) begin
                pending_val <= value;
            end
            if (fb && load) begin
                active_val <= value;
                pending    <= 1'b0;
            end else if (fb && pending) begin
                active_val <= pending_val;
                pending    <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    // p0: decode the current scan position
    always_comb begin
        code_p0 = select_code(active_val, int'(idx), en_mask, lz_en, dash_mode);
        an_p0   = anode_pattern(int'(idx), presc >= GUARD_END, en_mask);
    end

    // p1: registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_p1 <= CODE_BLANK;
            an_p1   <= '1;
            fs_p1   <= 1'b0;
        end else begin
            code_p1 <= code_p0;
            an_p1   <= an_p0;
            fs_p1   <= fb;
        end
    end

    assign digit_code  = code_p1;
    assign an          = an_p1;
    assign frame_start = fs_p1;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: a time-based display model predicts each
// output cycle; a negedge monitor compares against the DUT.
module tb_seg7_scan_ctrl;

    localparam int ND    = 8;
    localparam int RD    = 4;
    localparam int GC    = 1;
    localparam int FRAME = ND * RD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] value = '0;
    logic        load = 1'b0;
    logic        lz_en = 1'b0;
    logic        dash_mode = 1'b0;
    logic [7:0]  en_mask = 8'hFF;
    logic [4:0]  digit_code;
    logic [7:0]  an;
    logic        frame_start;

    typedef struct packed {
        logic [4:0] code;
        logic [7:0] an;
        logic       fs;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;

    // Model state: cycles since reset release, shown value, queued value.
    int          m_t = 0;
    logic [31:0] m_active = '0;
    logic [31:0] m_pend_val = '0;
    bit          m_pend = 1'b0;

    seg7_scan_ctrl #(
        .NUM_DIGITS   (ND),
        .REFRESH_DIV  (RD),
        .GUARD_CYCLES (GC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .value       (value),
        .load        (load),
        .lz_en       (lz_en),
        .dash_mode   (dash_mode),
        .en_mask     (en_mask),
        .digit_code  (digit_code),
        .an          (an),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0d got %h expected %h", name, m_t, got, exp);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        int   pos;
        int   digit;
        if (!rst_n) begin
            e = '{code: 5'h1F, an: 8'hFF, fs: 1'b0};
            m_t = 0;
            m_active = '0;
            m_pend_val = '0;
            m_pend = 1'b0;
        end else begin
            pos   = m_t % RD;
            digit = (m_t / RD) % ND;
            if (!en_mask[digit])
                e.code = 5'h1F;
            else if (dash_mode)
                e.code = 5'h10;
            else if (lz_en && digit > 0 && (m_active >> (4 * digit)) == 32'd0)
                e.code = 5'h1F;
            else
                e.code = {1'b0, m_active[4*digit +: 4]};
            e.an = (pos >= GC && en_mask[digit]) ? ~(8'd1 << digit) : 8'hFF;
            e.fs = (m_t % FRAME) == FRAME - 1;
            if ((m_t % FRAME) == FRAME - 1) begin
                if (load) begin
                    m_active = value;
                    m_pend   = 1'b0;
                end else if (m_pend) begin
                    m_active = m_pend_val;
                    m_pend   = 1'b0;
                end
            end else if (load) begin
                m_pend_val = value;
                m_pend     = 1'b1;
            end
            m_t++;
        end
        expq.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            expq.delete();
            check("rst_code", digit_code, 5'h1F);
            check("rst_an", an, 8'hFF);
            check("rst_fs", frame_start, 1'b0);
        end else if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty t=%0d got none expected one entry", m_t);
        end else begin
            e = expq.pop_front();
            check("code", digit_code, e.code);
            check("an", an, e.an);
            check("frame_start", frame_start, e.fs);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [31:0] v);
        load  = 1'b1;
        value = v;
        step(1);
        load  = 1'b0;
    endtask

    // Advance until the next sampled cycle sits at frame position target.
    task automatic wait_pos(input int target);
        int k;
        k = 0;
        while ((m_t % FRAME) != target && k < 2 * FRAME) begin
            step(1);
            k++;
        end
        checks++;
        if ((m_t % FRAME) != target) begin
            errors++;
            $display("FAIL wait_pos got %0d expected %0d", m_t % FRAME, target);
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        step(3);
        rst_n = 1'b1;

        // Idle scan of an all-zero value.
        step(70);

        // Mid-frame load appears only from the next frame.
        wait_pos(10);
        do_load(32'h1234_5678);
        step(2 * FRAME);

        // Last of two loads wins; then leading-zero blanking.
        wait_pos(3);
        do_load(32'hAAAA_AAAA);
        step(5);
        do_load(32'h0000_BEEF);
        step(FRAME + 8);
        lz_en = 1'b1;
        step(FRAME);
        lz_en = 1'b0;

        // Load exactly on the frame boundary.
        wait_pos(FRAME - 1);
        do_load(32'hCAFE_0001);
        check("pending_after_fb", dut.pending, 1'b0);
        step(FRAME);

        // Dash on enabled digits only.
        dash_mode = 1'b1;
        en_mask   = 8'h0F;
        step(FRAME + 4);
        dash_mode = 1'b0;
        en_mask   = 8'hFF;

        // Asynchronous reset while a load is pending in digit 5's slot.
        wait_pos(5 * RD + 1);
        do_load(32'h9999_9999);
        #2 rst_n = 1'b0;
        #1;
        check("async_code", digit_code, 5'h1F);
        check("async_an", an, 8'hFF);
        check("async_fs", frame_start, 1'b0);
        check("async_pending", dut.pending, 1'b0);
        step(2);
        rst_n = 1'b1;
        step(2 * FRAME);

        // Randomized traffic with live control changes.
        for (int i = 0; i < 1500; i++) begin
            load  = ($urandom_range(0, 15) == 0);
            value = $urandom;
            if ($urandom_range(0, 39) == 0) en_mask = 8'($urandom);
            if ($urandom_range(0, 29) == 0) lz_en = 1'($urandom);
            if ($urandom_range(0, 59) == 0) dash_mode = ($urandom_range(0, 3) == 0);
            step(1);
        end
        load = 1'b0;
        step(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog t=%0d got timeout expected completion", m_t);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Time-multiplexed scanner for the board's 8-digit seven-segment display, sitting directly upstream of the 5-bit-code-to-segment decoder. It holds a 32-bit display value and steps through the digits with a refresh prescaler. For each digit it drives the 5-bit decoder code (0x0-0xF hex, 0x10 dash, 0x1F blank) and the active-low anode enables. New values are committed only at frame boundaries, so a frame never mixes old and new digits.

Parameters:
NUM_DIGITS, 8, number of scanned digits (1..8); value nibble i drives digit i.
REFRESH_DIV, 100000, clk cycles per digit slot (>= GUARD_CYCLES+2).
GUARD_CYCLES, 16, cycles at the start of each slot with all anodes off (anti-ghosting).

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
value  input  32  value to display, nibble i -> digit i
load  input  1  single-cycle strobe; capture value into the pending register
lz_en  input  1  leading-zero blanking enable
dash_mode  input  1  show 0x10 (dash) on every enabled digit
en_mask  input  NUM_DIGITS  per-digit enable; 0 = digit dark
digit_code  output  5  code to the seven-segment decoder
an  output  NUM_DIGITS  anode enables, active-low
frame_start  output  1  one-cycle pulse when digit 0's slot begins

Behaviour:
- Reset: asynchronous on rst_n low, released synchronously into normal counting. Values during reset: presc=0, idx=0, active_val=0, pending_val=0, pending=0, an=all 1s, digit_code=5'h1F, frame_start=0.
- Prescaler presc counts 0..REFRESH_DIV-1 and wraps. At terminal count (tc), idx advances; idx NUM_DIGITS-1 wraps to 0.
- Frame boundary (fb) is tc with idx=NUM_DIGITS-1.
- load: pending_val<=value and pending<=1. A later load before commit overwrites; the last one wins.
- Commit at fb:
  - if pending, active_val<=pending_val and pending<=0.
  - If load is high in the fb cycle, value is committed directly (bypass) and pending ends at 0.
- Code selection, combinational on the current idx/active_val, in priority order:
  - en_mask[idx]=0 -> 5'h1F
  - dash_mode -> 5'h10
  - lz_en, idx>0, and all nibbles idx..NUM_DIGITS-1 zero -> 5'h1F
  - otherwise {1'b0, nibble[idx]}
  - Digit 0 is never blanked by lz_en, so value 0 shows "0".
- Anode: an[idx]=0 only when presc>=GUARD_CYCLES and en_mask[idx]=1; all other bits 1. Exactly one or zero bits are low at any time.
- Latency: digit_code, an and frame_start are registered, one cycle after the presc/idx state that produced them.
- frame_start is high for exactly one cycle, the first cycle of digit 0's slot, following fb.
- en_mask, lz_en and dash_mode are used live with no frame sync. Changes take effect within 1 cycle.
- Reset mid-scan: all state returns to reset values immediately and any pending value is discarded.

Decomposition:
- Shared package seg7_pkg holds:
  - SEG_CODE_W=5
  - constants CODE_DASH=5'h10 and CODE_BLANK=5'h1F
  - typedef seg_code_t (logic [4:0])
- Sub-module seg7_prescaler: a parameterised counter with tc output, reused for other board timers.
- Digit selection and anode logic stay inline.

Test Plan:
All scenarios use REFRESH_DIV=4, GUARD_CYCLES=1, en_mask=FF, lz_en=0, dash_mode=0 unless stated.
1. Reset release, no load -> an=FF and digit_code=1F while rst_n is low. After release, digits cycle 0..7 with code 0x00, one an bit low for 3 of every 4 cycles. frame_start pulses every 32 cycles.
2. load value=0x12345678 mid-frame -> the current frame is unchanged. From the next frame_start, digit i shows nibble i (digit0=0x8 ... digit7=0x1).
3. Two loads in one frame (0xAAAAAAAA, then 0x0000BEEF) -> the next frame shows 0x0000BEEF only. With lz_en=1, digits 4-7 give 1F and digits 0-3 give F,E,E,B.
4. load 0xCAFE0001 in exactly the fb cycle -> committed that boundary with no frame delay, and pending=0 afterwards.
5. dash_mode=1 with en_mask=0x0F -> digits 0-3 give 0x10 with their an bit low. Digits 4-7 give 1F with an all 1s during their slots.
6. Assert rst_n low while a load is pending in digit 5's slot -> outputs return to reset values asynchronously. After release, the display shows 0 and the pending value never appears.
